// File: rtl/tennis_pkg.sv
// Shared types for the PPM-link rally controller: FSM state encoding,
// statistic counter width and a saturating increment helper.
package tennis_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DRAIN,
        ST_DONE,
        ST_FAIL
    } rally_state_t;

    localparam int unsigned STAT_W = 8;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/timeout_timer.sv
// Reply timeout counter: counts enabled cycles and holds at TIMEOUT-1,
// so a count that reaches its limit while draining is still seen in WAIT.
module timeout_timer #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/rally_player.sv
// Multi-round packet rally controller: drives an Encoder, drains a Decoder,
// checks round-indexed sequences and retransmits on timeout with bounded retries.
module rally_player
    import tennis_pkg::*;
#(
    parameter int unsigned N_PKT     = 8,
    parameter int unsigned TIMEOUT   = 1000,
    parameter int unsigned N_ROUNDS  = 4,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned SERVE     = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            go,
    input  logic [N_PKT-1:0]                seed_tx,
    input  logic [N_PKT-1:0]                seed_rx,
    output logic                            start_ENC,
    input  logic                            avail_ENC,
    output logic [N_PKT-1:0]                data_ENC,
    input  logic [N_PKT-1:0]                data_DEC,
    input  logic                            avail_DEC,
    input  logic                            error_DEC,
    output logic                            read_DEC,
    output logic                            busy,
    output logic                            done,
    output logic                            failed,
    output logic [$clog2(N_ROUNDS+1)-1:0]   round_cnt,
    output logic [STAT_W-1:0]               retry_cnt,
    output logic [STAT_W-1:0]               err_cnt,
    output logic [STAT_W-1:0]               dup_cnt
);

    localparam int unsigned RW  = $clog2(N_ROUNDS + 1);
    localparam int unsigned CRW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    rally_state_t      state_q, state_d;
    logic [RW-1:0]     round_q, round_d;
    logic [CRW-1:0]    cons_q, cons_d;
    logic [STAT_W-1:0] retry_q, retry_d, err_q, err_d, dup_q, dup_d;
    logic [N_PKT-1:0]  data_q, data_d, pend_q, pend_d;
    logic              resend_q, resend_d;
    logic              start_q, start_d, read_q, read_d;

    logic              tmr_clr, tmr_en, tmr_exp, timeout;
    logic              dec_new, err_new, launch;
    logic [N_PKT-1:0]  exp_cur, exp_prev, tx_cur, tx_next;

    timeout_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_exp)
    );

    assign exp_cur  = seed_rx + N_PKT'(round_q);
    assign exp_prev = exp_cur - 1'b1;
    assign tx_cur   = seed_tx + N_PKT'(round_q);
    assign tx_next  = tx_cur + 1'b1;

    // The read acknowledge is registered, so decoder flags stay high for one
    // cycle after it; masking them then prevents a double read.
    assign dec_new = avail_DEC && !read_q;
    assign err_new = error_DEC && !read_q;

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        cons_d   = cons_q;
        retry_d  = retry_q;
        err_d    = err_q;
        dup_d    = dup_q;
        data_d   = data_q;
        pend_d   = pend_q;
        resend_d = resend_q;
        start_d  = 1'b0;
        read_d   = 1'b0;
        tmr_clr  = 1'b0;
        tmr_en   = (state_q == ST_WAIT || state_q == ST_DRAIN) &&
                   (SERVE != 0 || round_q != '0);
        timeout  = tmr_en && tmr_exp && (state_q == ST_WAIT);
        launch   = go && (state_q == ST_IDLE || state_q == ST_DONE ||
                          state_q == ST_FAIL);

        case (state_q)
            ST_SEND: begin
                if (avail_ENC) begin
                    start_d = 1'b1;
                    data_d  = pend_q;
                    tmr_clr = 1'b1;
                    if (SERVE != 0)
                        state_d = ST_WAIT;
                    else if (round_q == RW'(N_ROUNDS))
                        state_d = ST_DONE;
                    else
                        state_d = ST_DRAIN;
                end
            end
            ST_WAIT: begin
                if (err_new) begin
                    read_d  = 1'b1;
                    err_d   = sat_inc(err_q);
                    state_d = ST_DRAIN;
                end else if (dec_new) begin
                    read_d = 1'b1;
                    if (data_DEC == exp_cur) begin
                        round_d = round_q + 1'b1;
                        cons_d  = '0;
                        if (SERVE == 0) begin
                            pend_d  = tx_cur;
                            state_d = ST_SEND;
                        end else if (round_q == RW'(N_ROUNDS - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            pend_d  = tx_next;
                            state_d = ST_SEND;
                        end
                    end else if (round_q != '0 && data_DEC == exp_prev) begin
                        dup_d   = sat_inc(dup_q);
                        pend_d  = data_q;
                        state_d = ST_SEND;
                    end else begin
                        err_d   = sat_inc(err_q);
                        state_d = ST_DRAIN;
                    end
                end else if (timeout) begin
                    if (cons_q == CRW'(MAX_RETRY)) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = sat_inc(retry_q);
                        cons_d  = cons_q + 1'b1;
                        pend_d  = data_q;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_DRAIN: state_d = ST_WAIT;
            ST_DONE: begin
                // Stays DONE while re-answering a duplicate of the final round.
                if (resend_q && avail_ENC) begin
                    start_d  = 1'b1;
                    resend_d = 1'b0;
                end
                if (dec_new || err_new) begin
                    read_d = 1'b1;
                    if (!error_DEC && data_DEC == exp_prev) begin
                        dup_d    = sat_inc(dup_q);
                        resend_d = 1'b1;
                    end
                end
            end
            ST_FAIL: begin
                if (dec_new || err_new)
                    read_d = 1'b1;
            end
            default: ;
        endcase

        if (launch) begin
            round_d  = '0;
            cons_d   = '0;
            retry_d  = '0;
            err_d    = '0;
            dup_d    = '0;
            resend_d = 1'b0;
            start_d  = 1'b0;
            read_d   = 1'b0;
            tmr_clr  = 1'b1;
            pend_d   = seed_tx;
            state_d  = (SERVE != 0) ? ST_SEND : ST_WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            round_q  <= '0;
            cons_q   <= '0;
            retry_q  <= '0;
            err_q    <= '0;
            dup_q    <= '0;
            data_q   <= '0;
            pend_q   <= '0;
            resend_q <= 1'b0;
            start_q  <= 1'b0;
            read_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            cons_q   <= cons_d;
            retry_q  <= retry_d;
            err_q    <= err_d;
            dup_q    <= dup_d;
            data_q   <= data_d;
            pend_q   <= pend_d;
            resend_q <= resend_d;
            start_q  <= start_d;
            read_q   <= read_d;
        end
    end

    assign start_ENC = start_q;
    assign read_DEC  = read_q;
    assign data_ENC  = data_q;
    assign busy      = (state_q == ST_SEND) || (state_q == ST_WAIT) ||
                       (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign failed    = (state_q == ST_FAIL);
    assign round_cnt = round_q;
    assign retry_cnt = retry_q;
    assign err_cnt   = err_q;
    assign dup_cnt   = dup_q;

endmodule

// File: tb/tb_rally_player.sv
// Directed bench: a server and a returner instance, each driven by an
// encoder/decoder stub in the bench, with hand-computed expectations.
module tb_rally_player;

    localparam int T = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    logic       rst_n, s_go, r_go, enc_avail, sel;
    logic [7:0] dec_data;
    logic       dec_avail, dec_err;

    logic       s_start, s_read, s_busy, s_done, s_failed;
    logic [7:0] s_data, s_retry, s_errc, s_dup;
    logic [2:0] s_round;
    logic       r_start, r_read, r_busy, r_done, r_failed;
    logic [7:0] r_data, r_retry, r_errc, r_dup;
    logic [1:0] r_round;

    logic       m_start, m_read;
    logic [7:0] m_data;
    assign m_start = sel ? r_start : s_start;
    assign m_read  = sel ? r_read  : s_read;
    assign m_data  = sel ? r_data  : s_data;

    rally_player #(
        .N_PKT(8), .TIMEOUT(T), .N_ROUNDS(4), .MAX_RETRY(3), .SERVE(1)
    ) u_srv (
        .clk(clk), .rst_n(rst_n), .go(s_go),
        .seed_tx(8'h42), .seed_rx(8'h8f),
        .start_ENC(s_start), .avail_ENC(enc_avail), .data_ENC(s_data),
        .data_DEC(dec_data), .avail_DEC(dec_avail & ~sel), .error_DEC(dec_err & ~sel),
        .read_DEC(s_read), .busy(s_busy), .done(s_done), .failed(s_failed),
        .round_cnt(s_round), .retry_cnt(s_retry), .err_cnt(s_errc), .dup_cnt(s_dup)
    );

    rally_player #(
        .N_PKT(8), .TIMEOUT(T), .N_ROUNDS(2), .MAX_RETRY(3), .SERVE(0)
    ) u_ret (
        .clk(clk), .rst_n(rst_n), .go(r_go),
        .seed_tx(8'h8f), .seed_rx(8'h42),
        .start_ENC(r_start), .avail_ENC(enc_avail), .data_ENC(r_data),
        .data_DEC(dec_data), .avail_DEC(dec_avail & sel), .error_DEC(dec_err & sel),
        .read_DEC(r_read), .busy(r_busy), .done(r_done), .failed(r_failed),
        .round_cnt(r_round), .retry_cnt(r_retry), .err_cnt(r_errc), .dup_cnt(r_dup)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string tag, input logic [7:0] exp_data,
                              input int max_cyc, output int at);
        bit found = 1'b0;
        at = -1;
        for (int i = 0; i < max_cyc && !found; i++) begin
            @(posedge clk);
            #1;
            if (m_start) begin
                found = 1'b1;
                at    = cyc;
            end
        end
        check({tag, " start"}, 32'(found), 32'd1);
        if (found) check({tag, " data"}, 32'(m_data), 32'(exp_data));
    endtask

    task automatic deliver(input string tag, input logic [7:0] d,
                           input logic av, input logic er);
        bit found = 1'b0;
        dec_data  = d;
        dec_avail = av;
        dec_err   = er;
        for (int i = 0; i < 8 && !found; i++) begin
            @(posedge clk);
            #1;
            if (m_read) found = 1'b1;
        end
        dec_avail = 1'b0;
        dec_err   = 1'b0;
        check({tag, " read"}, 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, ns;
        rst_n = 1'b0; s_go = 1'b0; r_go = 1'b0; enc_avail = 1'b1; sel = 1'b0;
        dec_data = '0; dec_avail = 1'b0; dec_err = 1'b0;
        tick(2);
        check("rst start", 32'(s_start), 0);
        check("rst read",  32'(s_read), 0);
        check("rst data",  32'(s_data), 0);
        check("rst status", {s_busy, s_done, s_failed}, 0);
        check("rst counters", {s_round, s_retry, s_errc, s_dup}, 0);
        rst_n = 1'b1;
        tick(1);

        // Server rally with wrong packet, decoder error, duplicate and DONE resend.
        s_go = 1'b1; tick(1); s_go = 1'b0;
        check("go busy", 32'(s_busy), 1);
        wait_start("s r0", 8'h42, 5, t0);
        tick(1);
        check("start one cycle", 32'(s_start), 0);
        check("data stable", 32'(s_data), 32'h42);
        deliver("s r0 ok", 8'h8f, 1'b1, 1'b0);
        check("s r0 round", 32'(s_round), 1);
        wait_start("s r1", 8'h43, 5, t0);
        deliver("s bad", 8'h00, 1'b1, 1'b0);
        check("s bad err", 32'(s_errc), 1);
        check("s bad round", 32'(s_round), 1);
        deliver("s r1 ok", 8'h90, 1'b1, 1'b0);
        check("s r1 round", 32'(s_round), 2);
        wait_start("s r2", 8'h44, 5, t0);
        deliver("s derr", 8'h00, 1'b0, 1'b1);
        check("s derr err", 32'(s_errc), 2);
        wait_start("s retry", 8'h44, 3*T, t1);
        check("s timer kept", 32'(t1 - t0), 32'(T + 1));
        check("s retry cnt", 32'(s_retry), 1);
        deliver("s dup", 8'h90, 1'b1, 1'b0);
        check("s dup cnt", 32'(s_dup), 1);
        check("s dup round", 32'(s_round), 2);
        wait_start("s dup resend", 8'h44, 5, t0);
        deliver("s r2 ok", 8'h91, 1'b1, 1'b0);
        wait_start("s r3", 8'h45, 5, t0);
        deliver("s r3 ok", 8'h92, 1'b1, 1'b0);
        check("s done", {s_done, s_busy, s_failed}, 32'b100);
        check("s final counters", {s_round, s_retry, s_errc, s_dup}, {3'd4, 8'd1, 8'd2, 8'd1});
        deliver("s done dup", 8'h92, 1'b1, 1'b0);
        check("s done dup cnt", 32'(s_dup), 2);
        wait_start("s done resend", 8'h45, 5, t0);
        check("s still done", 32'(s_done), 1);

        // Restart from DONE; packet on the timeout cycle wins.
        s_go = 1'b1; tick(1); s_go = 1'b0;
        check("s restart clear", {s_round, s_retry, s_errc, s_dup}, 0);
        wait_start("s2 r0", 8'h42, 5, t0);
        repeat (T - 1) @(posedge clk);
        #1;
        deliver("s edge", 8'h8f, 1'b1, 1'b0);
        check("s edge round", 32'(s_round), 1);
        check("s edge no retry", 32'(s_retry), 0);
        wait_start("s2 r1", 8'h43, 5, t0);
        deliver("s err+avail", 8'h90, 1'b1, 1'b1);
        check("s err prio cnt", 32'(s_errc), 1);
        check("s err prio round", 32'(s_round), 1);

        // Asynchronous reset while read_DEC is high mid-rally.
        rst_n = 1'b0;
        #1;
        check("arst pulses", {s_start, s_read}, 0);
        check("arst data", 32'(s_data), 0);
        check("arst status", {s_busy, s_done, s_failed}, 0);
        check("arst counters", {s_round, s_errc}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1);

        // Silent peer: four sends, then FAIL.
        s_go = 1'b1; tick(1); s_go = 1'b0;
        wait_start("s3 r0", 8'h42, 5, t0);
        ns = 1;
        for (int i = 0; i < 6*T && !s_failed; i++) begin
            @(posedge clk);
            #1;
            if (s_start) ns++;
        end
        check("fail flag", 32'(s_failed), 1);
        check("fail sends", 32'(ns), 4);
        check("fail time", 32'(cyc - t0), 32'(4*T + 3));
        check("fail retry", 32'(s_retry), 3);
        check("fail busy", 32'(s_busy), 0);
        deliver("s fail drain", 8'h8f, 1'b1, 1'b0);
        check("fail discard", {s_round, s_errc, 7'd0, s_failed}, 32'd1);

        // Returner: no timeout before first packet, then timeouts apply.
        sel = 1'b1;
        r_go = 1'b1; tick(1); r_go = 1'b0;
        ns = 0;
        for (int i = 0; i < 3*T; i++) begin
            @(posedge clk);
            #1;
            if (r_start) ns++;
        end
        check("r no early send", 32'(ns), 0);
        check("r busy", 32'(r_busy), 1);
        deliver("r r0", 8'h42, 1'b1, 1'b0);
        check("r r0 round", 32'(r_round), 1);
        wait_start("r r0", 8'h8f, 5, t0);
        wait_start("r retry", 8'h8f, 3*T, t1);
        check("r retry time", 32'(t1 - t0), 32'(T + 1));
        check("r retry cnt", 32'(r_retry), 1);
        deliver("r r1", 8'h43, 1'b1, 1'b0);
        check("r r1 round", 32'(r_round), 2);
        wait_start("r r1", 8'h90, 5, t0);
        check("r done", {r_done, r_busy, r_failed}, 32'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rally_player.md
# rally_player

Parametrised packet-exchange controller for the optical PPM link: one instance per endpoint drives an `Encoder` and drains a `Decoder` to play a multi-round "tennis" rally. It sends a round-indexed data sequence, checks each received packet against the expected sequence, and retransmits on timeout with bounded retries. It also answers duplicates so a lost reply can be recovered. It generalises the fixed single-exchange `player1`/`player2` pair into one module with serve/return mode, round count, retry limit and status counters.

## Interface
- `N_PKT`, 8: packet width in bits; must match Encoder/Decoder.
- `TIMEOUT`, 1000: cycles in WAIT without a valid packet before a retransmit.
- `N_ROUNDS`, 4: rounds per rally; minimum 1.
- `MAX_RETRY`, 3: consecutive timeouts tolerated; the next timeout moves to FAIL.
- `SERVE`, 1: 1 = sends first (server); 0 = waits first (returner).

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `go`  in  1  one-cycle start pulse; honoured in IDLE, DONE and FAIL.
- `seed_tx`, `seed_rx`  in  N_PKT  base values of the transmit and expected sequences.
- `start_ENC`  out  1  one-cycle encoder start.
- `avail_ENC`  in  1  encoder idle/ready.
- `data_ENC`  out  N_PKT  packet to encode.
- `data_DEC`  in  N_PKT  decoded packet.
- `avail_DEC`, `error_DEC`  in  1  decoder has a packet / framing error.
- `read_DEC`  out  1  one-cycle acknowledge that clears decoder avail/error.
- `busy`, `done`, `failed`  out  1  rally status.
- `round_cnt`  out  $clog2(N_ROUNDS+1)  completed rounds.
- `retry_cnt`, `err_cnt`, `dup_cnt`  out  8 each  saturating statistics.

## Operation
- Sequences: tx(r) = seed_tx + r; exp(r) = seed_rx + r; both modulo 2^N_PKT.
- States: IDLE, SEND, WAIT, DRAIN, DONE, FAIL.
- IDLE: on `go`, clear all counters. Go to SEND if SERVE=1, else to WAIT.
- SEND: wait for `avail_ENC`=1, then pulse `start_ENC` with `data_ENC` = the current tx packet, and go to WAIT.
- WAIT, `error_DEC`=1: pulse `read_DEC`, increment `err_cnt`, go to DRAIN.
- WAIT, `avail_DEC`=1, data = exp(round_cnt): pulse `read_DEC`, increment `round_cnt`, clear consecutive retries.
  - Server: DONE if `round_cnt` reaches N_ROUNDS, else SEND tx(round_cnt).
  - Returner: SEND tx(round_cnt-1); after that send, DONE if `round_cnt` = N_ROUNDS, else DRAIN then WAIT.
- WAIT, `avail_DEC`=1, data = exp(round_cnt-1) with round_cnt > 0 (duplicate): pulse `read_DEC`, increment `dup_cnt`, resend the last tx packet, no round advance.
- WAIT, any other data: pulse `read_DEC`, increment `err_cnt`, go to DRAIN.
- Timeout in WAIT:
  - If consecutive retries = MAX_RETRY, go to FAIL.
  - Otherwise increment `retry_cnt` and the consecutive count, then resend the last tx packet via SEND.
  - The returner has no timeout before its first valid packet.
- DRAIN: one cycle, ignores decoder inputs, returns to WAIT. The timer is not reset.
- DONE: `done`=1. A duplicate of exp(N_ROUNDS-1) is still read and answered by resending the final tx packet; `done` stays 1.
- FAIL: `failed`=1. Decoder packets are read and discarded.

## Timing
- Reset values: state IDLE, all outputs 0, `data_ENC`=0, all counters 0. Reset mid-rally aborts immediately.
- `start_ENC` and `read_DEC` are registered, and each is high for exactly one cycle per event.
- `data_ENC` is stable from the `start_ENC` cycle until the next `start_ENC`.
- The timeout counter clears on every SEND→WAIT transition and increments each cycle in WAIT/DRAIN.
  - Timeout fires on the cycle the count equals TIMEOUT-1.
  - A valid packet arriving that same cycle takes priority over the timeout.
- If `error_DEC` and `avail_DEC` are both high, the error takes priority.
- Statistics counters saturate at 255.
- `busy` = state in {SEND, WAIT, DRAIN}.
- `go` in SEND/WAIT/DRAIN is ignored.

## Structure
- Shared package `tennis_pkg`: state enum `rally_state_t` and the statistic counter width constant.
- Sub-module `timeout_timer` (parameter TIMEOUT; ports `clr`, `en`, `expired`).

## Test plan
- Two instances back-to-back through Encoder/Decoder (SERVE=1/0, seeds 0x42/0x8f swapped, N_ROUNDS=4) -> both `done`, `round_cnt`=4, server sends 0x42..0x45, returner sends 0x8f..0x92, `err_cnt`=0.
- Suppress the returner's 2nd reply pulse train -> server times out after TIMEOUT cycles and resends 0x43; returner increments `dup_cnt`=1 and resends 0x90; rally completes with server `retry_cnt`=1.
- Decoder stub injects `error_DEC` in round 0 -> `read_DEC` pulse, `err_cnt`=1, timer not reset, retransmit follows on timeout.
- Returner silent, MAX_RETRY=3 -> server issues exactly 4 `start_ENC`, then `failed`=1 at (4·TIMEOUT + send overhead) cycles.
- Wrong packet 0x00 delivered -> `err_cnt`=1, no round advance; correct packet next -> advance.
- Assert `rst_n`=0 mid-WAIT -> all outputs 0 in the same cycle; `go` after release starts a clean rally.
